id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have reset, input, 1; asynchronous, active-high.
REQ-003 SHALL have in_valid, input, 1; decode slot holds an instruction.
REQ-004 SHALL have in_ready, output, 1; stage accepts this cycle.
REQ-005 SHALL have instr, input, 32; raw RV32I instruction word.
REQ-006 SHALL have rs1_data / rs2_data, input, 32 each; register-file read data.
REQ-007 SHALL have stall, input, 1; execute consumer cannot take the held entry.
REQ-008 SHALL have flush, input, 1; discard held entry and any incoming one.
REQ-009 SHALL have wb_valid, input, 1; wb_rd, input, 5; wb_data, input, 32; writeback bypass source.
REQ-010 SHALL have ex_valid, output, 1; registered entry present.
REQ-011 SHALL have alu_operation, output, 4; registered ALU opcode.
REQ-012 SHALL have alu_rs1 / alu_rs2, output, 32 each; registered ALU operands.
REQ-013 SHALL have rd_addr, output, 5; registered destination; illegal, output, 1; registered decode fault.

Function
REQ-014 in_ready SHALL equal !flush & (!ex_valid | !stall), combinational.
REQ-015 Accept SHALL occur when in_valid & in_ready; all outputs load on that edge; latency one cycle.
REQ-016 With ex_valid & stall & !flush, all outputs SHALL hold unchanged.
REQ-017 With !in_valid & in_ready, ex_valid SHALL go 0 next edge; other outputs hold.
REQ-018 flush SHALL clear ex_valid and illegal next edge, overriding stall and in_valid; the incoming instruction is dropped.
REQ-019 Decode opcode 0110011 (R) and 0010011 (I) only; funct3 map: 000 ADD=3 (SUB=4 when R and instr[30]), 111 AND=1, 110 OR=2, 100 XOR=9, 001 SLL=5, 101 SRL=7 (SRA=6 when instr[30]), 010 SLT=8.
REQ-020 Any other opcode, funct3 011, or I-type 001 with instr[30]=1 SHALL load illegal=1, alu_operation=0, alu_rs1=alu_rs2=0, ex_valid=1.
REQ-021 alu_rs2 SHALL be rs2_data for R-type; sign-extended instr[31:20] for I-type; zero-extended instr[24:20] for I-type shifts.
REQ-022 rd_addr SHALL be instr[11:7]; rd=0 passes unchanged.
REQ-023 Bypass operand selection SHALL occur only at accept; held entries are never re-bypassed.

Reset
REQ-024 reset SHALL immediately clear ex_valid, illegal, alu_operation, alu_rs1, alu_rs2, rd_addr to 0.
REQ-025 Reset mid-stall SHALL drop the held entry; first accept allowed on the first edge after reset deasserts.

Configuration
REQ-026 Macro ID_EX_BYPASS_EN defined: at accept, if wb_valid & wb_rd!=0 & wb_rd==instr[19:15], alu_rs1 SHALL take wb_data; likewise alu_rs2 for R-type with instr[24:20].
REQ-027 ID_EX_BYPASS_EN undefined: wb_* ports SHALL exist but be ignored; operands come only from rs1_data/rs2_data/immediate.

Verification
REQ-028 instr 0x40208033 (sub x0? rd=0,rs1=1,rs2=2), rs1_data=10, rs2_data=3, in_valid=1 -> next edge ex_valid=1, alu_operation=4, alu_rs1=10, alu_rs2=3, rd_addr=0.
REQ-029 instr 0xFFF0A093 (slti x1,x1,-1 decoded as 010 -> 8) rs1_data=5 -> alu_operation=8, alu_rs2=0xFFFFFFFF, rd_addr=1.
REQ-030 Accept ADD, then stall=1 for 3 cycles with new in_valid -> in_ready=0, outputs frozen; stall=0 -> new entry loads next edge.
REQ-031 stall=1, flush=1, in_valid=1 same cycle -> in_ready=0, next edge ex_valid=0, illegal=0.
REQ-032 instr funct3 011 (sltu) -> ex_valid=1, illegal=1, alu_operation=0, operands 0.
REQ-033 BYPASS_EN: wb_valid=1, wb_rd=1, wb_data=0x55, instr rs1=1, rs1_data=0x11 -> alu_rs1=0x55; wb_rd=0 -> alu_rs1=rs1_data; macro off -> 0x11.

Source files
------------

// File: rtl/id_ex_stage.sv
//------------------------------------------------------------------------------
// Module      : id_ex_stage
// Description : Decode/execute pipeline register for a reduced RV32I ALU
//               subset. Decodes R-type (0110011) and I-type (0010011)
//               instructions into an ALU opcode plus two 32-bit operands and
//               holds them for the execute stage under stall/flush control.
//               Optional macro ID_EX_BYPASS_EN enables writeback-to-operand
//               forwarding at accept time.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [3:0]  alu_operation,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [4:0]  rd_addr,
  output logic        illegal
);

  // Major opcodes accepted by this stage
  localparam logic [6:0] OPC_REG = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  // funct3 field values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // ALU opcode encoding presented to execute
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRA  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt_bit;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [4:0]  rd_idx;
  logic [31:0] imm_i;
  logic [31:0] shamt_i;
  logic        is_reg;
  logic        is_imm;
  logic        is_shift;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign alt_bit  = instr[30];
  assign rs1_idx  = instr[19:15];
  assign rs2_idx  = instr[24:20];
  assign rd_idx   = instr[11:7];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign shamt_i  = {27'd0, instr[24:20]};
  assign is_reg   = (opcode == OPC_REG);
  assign is_imm   = (opcode == OPC_IMM);
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL);

  // Source operands after optional writeback forwarding. Forwarding is only
  // ever applied to the instruction being accepted; a held entry keeps the
  // operands it captured.
  logic [31:0] src1;
  logic [31:0] src2;

`ifdef ID_EX_BYPASS_EN
  logic wb_hit_rs1;
  logic wb_hit_rs2;

  assign wb_hit_rs1 = wb_valid && (wb_rd != 5'd0) && (wb_rd == rs1_idx);
  assign wb_hit_rs2 = wb_valid && (wb_rd != 5'd0) && (wb_rd == rs2_idx) && is_reg;
  assign src1       = wb_hit_rs1 ? wb_data : rs1_data;
  assign src2       = wb_hit_rs2 ? wb_data : rs2_data;
`else
  // Writeback ports exist for pin compatibility but carry no function here.
  logic unused_bypass;

  assign unused_bypass = ^{wb_valid, wb_rd, wb_data, rs1_idx};
  assign src1          = rs1_data;
  assign src2          = rs2_data;
`endif

  // Decoded (pre-register) view of the incoming instruction
  logic        dec_illegal;
  logic [3:0]  dec_op;
  logic [31:0] dec_rs1;
  logic [31:0] dec_rs2;

  // Translate opcode/funct3/bit30 into an ALU operation and pick operand B
  always_comb begin
    dec_illegal = 1'b0;
    dec_op      = ALU_NONE;
    dec_rs1     = src1;
    dec_rs2     = src2;

    if (!(is_reg || is_imm)) begin
      dec_illegal = 1'b1;
    end else begin
      case (funct3)
        F3_ADD:  dec_op = (is_reg && alt_bit) ? ALU_SUB : ALU_ADD;
        F3_AND:  dec_op = ALU_AND;
        F3_OR:   dec_op = ALU_OR;
        F3_XOR:  dec_op = ALU_XOR;
        F3_SLT:  dec_op = ALU_SLT;
        F3_SLTU: dec_illegal = 1'b1;
        F3_SLL: begin
          dec_op = ALU_SLL;
          // slli has no alternate form; bit 30 set is an encoding fault
          if (is_imm && alt_bit) begin
            dec_illegal = 1'b1;
          end
        end
        F3_SRL:  dec_op = alt_bit ? ALU_SRA : ALU_SRL;
        default: dec_illegal = 1'b1;
      endcase

      // Immediate forms replace operand B; shifts use the 5-bit shamt only
      if (is_imm) begin
        dec_rs2 = is_shift ? shamt_i : imm_i;
      end
    end

    // Faulted instructions travel with scrubbed payload
    if (dec_illegal) begin
      dec_op  = ALU_NONE;
      dec_rs1 = 32'd0;
      dec_rs2 = 32'd0;
    end
  end

  // Pipeline register state
  logic        ex_valid_q, ex_valid_d;
  logic        illegal_q,  illegal_d;
  logic [3:0]  alu_op_q,   alu_op_d;
  logic [31:0] alu_rs1_q,  alu_rs1_d;
  logic [31:0] alu_rs2_q,  alu_rs2_d;
  logic [4:0]  rd_addr_q,  rd_addr_d;
  logic        ready;
  logic        accept;

  // The slot can take a new entry whenever it is empty or being drained
  assign ready  = !flush && (!ex_valid_q || !stall);
  assign accept = in_valid && ready;

  // Next-state selection: flush beats everything, then accept/bubble, else hold
  always_comb begin
    ex_valid_d = ex_valid_q;
    illegal_d  = illegal_q;
    alu_op_d   = alu_op_q;
    alu_rs1_d  = alu_rs1_q;
    alu_rs2_d  = alu_rs2_q;
    rd_addr_d  = rd_addr_q;

    if (flush) begin
      ex_valid_d = 1'b0;
      illegal_d  = 1'b0;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      illegal_d  = dec_illegal;
      alu_op_d   = dec_op;
      alu_rs1_d  = dec_rs1;
      alu_rs2_d  = dec_rs2;
      rd_addr_d  = rd_idx;
    end else if (ready) begin
      // Slot drained with nothing to replace it: emit a bubble
      ex_valid_d = 1'b0;
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      alu_op_q   <= 4'd0;
      alu_rs1_q  <= 32'd0;
      alu_rs2_q  <= 32'd0;
      rd_addr_q  <= 5'd0;
    end else begin
      ex_valid_q <= ex_valid_d;
      illegal_q  <= illegal_d;
      alu_op_q   <= alu_op_d;
      alu_rs1_q  <= alu_rs1_d;
      alu_rs2_q  <= alu_rs2_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign in_ready      = ready;
  assign ex_valid      = ex_valid_q;
  assign illegal       = illegal_q;
  assign alu_operation = alu_op_q;
  assign alu_rs1       = alu_rs1_q;
  assign alu_rs2       = alu_rs2_q;
  assign rd_addr       = rd_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. A behavioural model of
//               the stage is compared against the DUT every cycle, and
//               directed vectors carry hand-computed literal expectations.
//               Honours ID_EX_BYPASS_EN the same way the design does.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        stall;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [3:0]  alu_operation;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [4:0]  rd_addr;
  logic        illegal;

  int n_pass  = 0;
  int n_total = 0;

  id_ex_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .stall        (stall),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .ex_valid     (ex_valid),
    .alu_operation(alu_operation),
    .alu_rs1      (alu_rs1),
    .alu_rs2      (alu_rs2),
    .rd_addr      (rd_addr),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU code per funct3 (011 has no code; it is rejected separately)
  localparam int OPTAB [8] = '{3, 5, 8, 0, 9, 7, 2, 1};

  // Model state
  logic        m_valid;
  logic        m_ill;
  logic [3:0]  m_op;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [4:0]  m_rd;

  task automatic model_accept();
    logic        r_form;
    logic        i_form;
    int          f3;
    logic        bad;
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    r_form = (instr[6:0] == 7'h33);
    i_form = (instr[6:0] == 7'h13);
    f3     = int'(instr[14:12]);
    a      = rs1_data;
    b      = rs2_data;
`ifdef ID_EX_BYPASS_EN
    if (wb_valid && wb_rd != 5'd0) begin
      if (wb_rd == instr[19:15]) a = wb_data;
      if (r_form && wb_rd == instr[24:20]) b = wb_data;
    end
`endif
    op  = OPTAB[f3];
    bad = !(r_form || i_form) || f3 == 3 || (i_form && f3 == 1 && instr[30]);
    if (r_form && f3 == 0 && instr[30]) op = 4;
    if (f3 == 5 && instr[30]) op = 6;
    if (i_form) begin
      if (f3 == 1 || f3 == 5) b = 32'(instr[24:20]);
      else b = {{20{instr[31]}}, instr[31:20]};
    end
    if (bad) begin
      op = 0;
      a  = 0;
      b  = 0;
    end
    m_valid = 1'b1;
    m_ill   = bad;
    m_op    = 4'(op);
    m_a     = a;
    m_b     = b;
    m_rd    = instr[11:7];
  endtask

  // Reference model of the pipeline slot
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0;
      m_ill   = 1'b0;
      m_op    = 4'd0;
      m_a     = 32'd0;
      m_b     = 32'd0;
      m_rd    = 5'd0;
    end else if (flush) begin
      m_valid = 1'b0;
      m_ill   = 1'b0;
    end else if (!m_valid || !stall) begin
      if (in_valid) model_accept();
      else m_valid = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("cyc.in_ready", 32'(in_ready), 32'(!flush && (!m_valid || !stall)));
    chk("cyc.ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("cyc.illegal",  32'(illegal),  32'(m_ill));
    chk("cyc.alu_op",   32'(alu_operation), 32'(m_op));
    chk("cyc.alu_rs1",  alu_rs1, m_a);
    chk("cyc.alu_rs2",  alu_rs2, m_b);
    chk("cyc.rd_addr",  32'(rd_addr), 32'(m_rd));
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic st, input logic fl);
    in_valid = v;
    instr    = ins;
    rs1_data = r1;
    rs2_data = r2;
    stall    = st;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_SUB  = 32'h40208033; // sub  x0,x1,x2
  localparam logic [31:0] I_SLTI = 32'hFFF0A093; // slti x1,x1,-1
  localparam logic [31:0] I_ADD  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_XOR  = 32'h0062C233; // xor  x4,x5,x6
  localparam logic [31:0] I_SLTU = 32'h0020B1B3; // sltu x3,x1,x2
  localparam logic [31:0] I_LUI  = 32'h000010B7; // lui  x1,1
  localparam logic [31:0] I_SRAI = 32'h4030D093; // srai x1,x1,3
  localparam logic [31:0] I_BADS = 32'h40309093; // slli with bit30 set

  initial begin
    reset    = 1'b1;
    wb_valid = 1'b0;
    wb_rd    = 5'd0;
    wb_data  = 32'd0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset.ex_valid", 32'(ex_valid), 32'd0);
    chk("reset.alu_rs1", alu_rs1, 32'd0);
    chk("reset.rd_addr", 32'(rd_addr), 32'd0);
    reset = 1'b0;

    // sub with rd=0
    drive(1'b1, I_SUB, 32'd10, 32'd3, 1'b0, 1'b0);
    tick();
    chk("sub.ex_valid", 32'(ex_valid), 32'd1);
    chk("sub.op", 32'(alu_operation), 32'd4);
    chk("sub.rs1", alu_rs1, 32'd10);
    chk("sub.rs2", alu_rs2, 32'd3);
    chk("sub.rd", 32'(rd_addr), 32'd0);

    // slti with negative immediate
    drive(1'b1, I_SLTI, 32'd5, 32'd77, 1'b0, 1'b0);
    tick();
    chk("slti.op", 32'(alu_operation), 32'd8);
    chk("slti.rs1", alu_rs1, 32'd5);
    chk("slti.rs2", alu_rs2, 32'hFFFFFFFF);
    chk("slti.rd", 32'(rd_addr), 32'd1);

    // add, then three stalled cycles with a new instruction waiting
    drive(1'b1, I_ADD, 32'd7, 32'd8, 1'b0, 1'b0);
    tick();
    chk("add.op", 32'(alu_operation), 32'd3);
    chk("add.rd", 32'(rd_addr), 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, I_XOR, 32'h50, 32'h60, 1'b1, 1'b0);
      wb_valid = 1'b1;
      wb_rd    = 5'd1;
      wb_data  = 32'hDEAD;
      #1;
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("stall.op", 32'(alu_operation), 32'd3);
      chk("stall.rs1", alu_rs1, 32'd7);
      chk("stall.rs2", alu_rs2, 32'd8);
    end
    wb_valid = 1'b0;
    drive(1'b1, I_XOR, 32'h50, 32'h60, 1'b0, 1'b0);
    #1;
    chk("unstall.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("xor.op", 32'(alu_operation), 32'd9);
    chk("xor.rs1", alu_rs1, 32'h50);
    chk("xor.rd", 32'(rd_addr), 32'd4);

    // bubble: valid drops, payload holds
    drive(1'b0, I_SUB, 32'd1, 32'd2, 1'b0, 1'b0);
    tick();
    chk("bubble.ex_valid", 32'(ex_valid), 32'd0);
    chk("bubble.op", 32'(alu_operation), 32'd9);

    // sltu is rejected
    drive(1'b1, I_SLTU, 32'h1234, 32'h5678, 1'b0, 1'b0);
    tick();
    chk("sltu.ex_valid", 32'(ex_valid), 32'd1);
    chk("sltu.illegal", 32'(illegal), 32'd1);
    chk("sltu.op", 32'(alu_operation), 32'd0);
    chk("sltu.rs1", alu_rs1, 32'd0);
    chk("sltu.rs2", alu_rs2, 32'd0);

    // flush with stall and a pending instruction
    drive(1'b1, I_ADD, 32'd9, 32'd9, 1'b1, 1'b1);
    #1;
    chk("flush.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("flush.ex_valid", 32'(ex_valid), 32'd0);
    chk("flush.illegal", 32'(illegal), 32'd0);

    // other opcodes and shift encodings
    drive(1'b1, I_LUI, 32'd3, 32'd4, 1'b0, 1'b0);
    tick();
    chk("lui.illegal", 32'(illegal), 32'd1);
    drive(1'b1, I_SRAI, 32'h80000000, 32'd99, 1'b0, 1'b0);
    tick();
    chk("srai.op", 32'(alu_operation), 32'd6);
    chk("srai.rs2", alu_rs2, 32'd3);
    chk("srai.illegal", 32'(illegal), 32'd0);
    drive(1'b1, I_BADS, 32'd1, 32'd1, 1'b0, 1'b0);
    tick();
    chk("slli30.illegal", 32'(illegal), 32'd1);

    // writeback forwarding
    wb_valid = 1'b1;
    wb_rd    = 5'd1;
    wb_data  = 32'h55;
    drive(1'b1, I_ADD, 32'h11, 32'h22, 1'b0, 1'b0);
    tick();
`ifdef ID_EX_BYPASS_EN
    chk("byp.rs1", alu_rs1, 32'h55);
`else
    chk("byp.rs1", alu_rs1, 32'h11);
`endif
    chk("byp.rs2", alu_rs2, 32'h22);
    wb_rd = 5'd0;
    tick();
    chk("byp_x0.rs1", alu_rs1, 32'h11);
    wb_rd = 5'd2;
    tick();
`ifdef ID_EX_BYPASS_EN
    chk("byp2.rs2", alu_rs2, 32'h55);
`else
    chk("byp2.rs2", alu_rs2, 32'h22);
`endif
    wb_valid = 1'b0;

    // reset in the middle of a stall drops the held entry
    drive(1'b1, I_ADD, 32'd7, 32'd8, 1'b0, 1'b0);
    tick();
    drive(1'b1, I_XOR, 32'd1, 32'd2, 1'b1, 1'b0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid.ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_mid.rs1", alu_rs1, 32'd0);
    chk("rst_mid.op", 32'(alu_operation), 32'd0);
    #3;
    reset = 1'b0;
    drive(1'b1, I_SUB, 32'd20, 32'd6, 1'b0, 1'b0);
    tick();
    chk("post_rst.ex_valid", 32'(ex_valid), 32'd1);
    chk("post_rst.op", 32'(alu_operation), 32'd4);
    chk("post_rst.rs1", alu_rs1, 32'd20);

    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
